fetch_stage: RTL and testbench
==============================

# fetch_stage

Instruction fetch stage for the RISC-V core. Owns the program counter, drives the word address into the combinational-read instruction memory, and captures the returned instruction together with its PC into a small FIFO. Decode consumes the FIFO through a valid/ready handshake. Execute can redirect fetch for taken branches and jumps, which flushes everything already fetched.

## Interface

Parameters:
- RESET_PC, 32'h0000_0000, PC value loaded on reset; bits [1:0] must be 0.
- DEPTH, 2, number of FIFO entries; power of two, at least 2.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  asynchronous, active-high reset.
- fetch_en  in  1  fetch enable; when 0, no new fetch is issued and the PC holds.
- imem_addr  out  32  byte address to the instruction memory; equals the PC register, combinationally.
- imem_rd  in  32  instruction word returned by the memory in the same cycle.
- redirect_valid  in  1  redirect request from execute.
- redirect_pc  in  32  redirect target; bits [1:0] are ignored.
- out_valid  out  1  head entry is valid.
- out_ready  in  1  decode accepts the head entry.
- out_instr  out  32  instruction at the head.
- out_pc  out  32  PC of the head instruction.
- out_pc_plus4  out  32  out_pc + 4, modulo 2^32.

## Operation

- State:
  - pc (32 bits).
  - FIFO storage: DEPTH entries of {pc, instr}.
  - Read pointer and write pointer, each log2(DEPTH) bits, wrapping naturally.
  - count, 0..DEPTH.
- pop = out_valid & out_ready.
- push = fetch_en & ~redirect_valid & (count < DEPTH | pop).
  - A pop in the same cycle frees a slot, so push is allowed even when the FIFO is full.
- On push:
  - Write {pc, imem_rd} at the write pointer and advance the write pointer.
  - pc <= pc + 4, modulo 2^32. 0xFFFF_FFFC wraps to 0x0000_0000.
- On pop: advance the read pointer.
- count update:
  - Increments on push only.
  - Decrements on pop only.
  - Unchanged on push and pop together.
- Redirect has priority over everything:
  - pc <= {redirect_pc[31:2], 2'b00}.
  - Both pointers and count reset to 0.
  - No push occurs.
- out_valid = (count != 0) & ~redirect_valid.
  - No handshake can complete during a redirect cycle.
  - A flushed entry is therefore never accepted downstream.
- out_instr and out_pc show the head entry's fields.
  - When count == 0 they hold stale contents, which downstream must ignore.
- fetch_en = 0:
  - No push; the PC holds.
  - Pops continue, so the FIFO drains.
  - Redirects are still honoured.
- Reset (asynchronous, takes effect immediately; any in-flight entries are discarded):
  - pc = RESET_PC, so imem_addr = RESET_PC.
  - Pointers and count = 0, so out_valid = 0.
  - FIFO storage cleared to 0, so out_instr = 0, out_pc = 0, out_pc_plus4 = 4.
- No address range check: PCs beyond the memory size are fetched as-is.

## Timing

- imem_addr → imem_rd is a same-cycle combinational path. The instruction is captured at the edge that ends the cycle in which imem_addr was presented.
- Fetch latency is 1 cycle: an instruction fetched in cycle N appears at out_* with out_valid = 1 in cycle N+1.
- First instruction after reset deassertion:
  - Captured at the first rising edge.
  - out_valid rises in the following cycle.
- Throughput is 1 instruction per cycle while out_ready = 1 and fetch_en = 1.
- Redirect asserted in cycle N:
  - out_valid = 0 in cycle N.
  - imem_addr = target in cycle N+1.
  - The target instruction is at the head with out_valid = 1 in cycle N+2.
- Backpressure:
  - With out_ready = 0 and the FIFO full, the PC stalls and imem_addr holds.
  - No instruction is lost or duplicated when out_ready returns.

## Test plan

- **Streaming.** Memory model returns word = address ^ 32'hA5A5_0000; reset, then fetch_en = 1, out_ready = 1 → out_pc = 0x0, 0x4, 0x8, … on consecutive cycles starting 1 cycle after reset release; out_instr matches the model; out_pc_plus4 = out_pc + 4.
- **Backpressure.** out_ready = 0 from cycle 0 → count saturates at 2, imem_addr holds at 0x8, out_pc holds at 0x0; release out_ready → 0x0, 0x4, 0x8, 0xC with no gap, loss or duplicate.
- **Redirect while full.** FIFO full, redirect_valid = 1 with redirect_pc = 0x100 → out_valid = 0 that cycle and the next; out_pc = 0x100 the cycle after; old entries never accepted; also check a redirect in the same cycle as out_ready = 1.
- **Misaligned target.** redirect_pc = 0x0000_0103 → imem_addr = 0x100, out_pc = 0x100.
- **Wrap-around.** RESET_PC = 0xFFFF_FFF8 → out_pc sequence 0xFFFF_FFF8, 0xFFFF_FFFC, 0x0000_0000; out_pc_plus4 at 0xFFFF_FFFC is 0x0.
- **Async reset and fetch_en.**
  - Assert rst mid-stream between edges → out_valid = 0 and imem_addr = RESET_PC immediately.
  - fetch_en = 0 with 2 entries queued and out_ready = 1 → both drain, then out_valid = 0 and the PC is unchanged.

Source files
------------

// File: rtl/fetch_stage.sv
// Instruction fetch: PC register drives imem, {pc, instr} captured into a small FIFO for decode.
// Latency 1 cycle imem_addr to out_valid; PC stalls when FIFO full and not popping; redirect flushes.

module fetch_fifo #(
    parameter int W     = 64,
    parameter int DEPTH = 2
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         flush,
    input  logic                         push,
    input  logic [W-1:0]                 wr_dat,
    input  logic                         pop,
    output logic [W-1:0]                 rd_dat,
    output logic [$clog2(DEPTH+1)-1:0]   count
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);

    logic [W-1:0]  mem [DEPTH];
    logic [PW-1:0] rptr;
    logic [PW-1:0] wptr;

    assign rd_dat = mem[rptr];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rptr  <= '0;
            wptr  <= '0;
            count <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else if (flush) begin
            rptr  <= '0;
            wptr  <= '0;
            count <= '0;
        end else begin
            if (push) begin
                mem[wptr] <= wr_dat;
                wptr      <= wptr + PW'(1);
            end
            if (pop) begin
                rptr <= rptr + PW'(1);
            end
            if (push && !pop) begin
                count <= count + CW'(1);
            end else if (pop && !push) begin
                count <= count - CW'(1);
            end
        end
    end
endmodule

module fetch_stage #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int          DEPTH    = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        fetch_en,
    output logic [31:0] imem_addr,
    input  logic [31:0] imem_rd,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_instr,
    output logic [31:0] out_pc,
    output logic [31:0] out_pc_plus4
);
    localparam int CW = $clog2(DEPTH + 1);

    logic [31:0]   pc;
    logic [CW-1:0] count;
    logic [63:0]   head_dat;
    logic          full;
    logic          push;
    logic          pop;

    assign imem_addr = pc;
    assign full      = (count == CW'(DEPTH));
    // Redirect masks the head so a flushed entry can never handshake.
    assign out_valid = (count != '0) & ~redirect_valid;
    assign pop       = out_valid & out_ready;
    assign push      = fetch_en & ~redirect_valid & (~full | pop);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pc <= RESET_PC;
        end else if (redirect_valid) begin
            pc <= {redirect_pc[31:2], 2'b00};
        end else if (push) begin
            pc <= pc + 32'd4;
        end
    end

    fetch_fifo #(
        .W     (64),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk    (clk),
        .rst    (rst),
        .flush  (redirect_valid),
        .push   (push),
        .wr_dat ({pc, imem_rd}),
        .pop    (pop),
        .rd_dat (head_dat),
        .count  (count)
    );

    assign out_pc       = head_dat[63:32];
    assign out_instr    = head_dat[31:0];
    assign out_pc_plus4 = out_pc + 32'd4;
endmodule

// File: tb/tb_fetch_stage.sv
// Bench for fetch_stage: queue-based reference model plus directed checks on a second, wrapping instance.
module tb_fetch_stage;
    localparam int DEPTH = 2;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        fetch_en = 1'b0;
    logic        redirect_valid = 1'b0;
    logic [31:0] redirect_pc = 32'd0;
    logic        out_ready = 1'b0;
    logic [31:0] imem_addr, imem_rd, out_instr, out_pc, out_pc_plus4;
    logic        out_valid;

    logic        fe2 = 1'b0;
    logic        rdy2 = 1'b0;
    logic        rv2 = 1'b0;
    logic [31:0] rpc2 = 32'd0;
    logic [31:0] imem_addr2, imem_rd2, out_instr2, out_pc2, out_pc_plus4_2;
    logic        out_valid2;

    int checks = 0;
    int errors = 0;

    logic [31:0] m_pc;
    logic [31:0] q[$];

    always #5 clk = ~clk;

    function automatic logic [31:0] memf(input logic [31:0] a);
        return a ^ 32'hA5A5_0000;
    endfunction

    assign imem_rd  = memf(imem_addr);
    assign imem_rd2 = memf(imem_addr2);

    fetch_stage #(.RESET_PC(32'h0000_0000), .DEPTH(DEPTH)) dut (
        .clk(clk), .rst(rst), .fetch_en(fetch_en), .imem_addr(imem_addr), .imem_rd(imem_rd),
        .redirect_valid(redirect_valid), .redirect_pc(redirect_pc), .out_valid(out_valid),
        .out_ready(out_ready), .out_instr(out_instr), .out_pc(out_pc), .out_pc_plus4(out_pc_plus4)
    );

    fetch_stage #(.RESET_PC(32'hFFFF_FFF8), .DEPTH(DEPTH)) dut2 (
        .clk(clk), .rst(rst), .fetch_en(fe2), .imem_addr(imem_addr2), .imem_rd(imem_rd2),
        .redirect_valid(rv2), .redirect_pc(rpc2), .out_valid(out_valid2),
        .out_ready(rdy2), .out_instr(out_instr2), .out_pc(out_pc2), .out_pc_plus4(out_pc_plus4_2)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Check outputs against the model, advance the model by one cycle, then move to the next negedge.
    task automatic step();
        logic pop_m;
        logic push_m;
        #1;
        chk("imem_addr", imem_addr, m_pc);
        chk("out_valid", {31'd0, out_valid}, (q.size() != 0 && !redirect_valid) ? 32'd1 : 32'd0);
        if (q.size() != 0) begin
            chk("out_pc", out_pc, q[0]);
            chk("out_instr", out_instr, memf(q[0]));
            chk("out_pc_plus4", out_pc_plus4, q[0] + 32'd4);
        end
        if (redirect_valid) begin
            q.delete();
            m_pc = {redirect_pc[31:2], 2'b00};
        end else begin
            pop_m  = (q.size() != 0) && out_ready;
            push_m = fetch_en && ((q.size() < DEPTH) || pop_m);
            if (pop_m) void'(q.pop_front());
            if (push_m) begin
                q.push_back(m_pc);
                m_pc = m_pc + 32'd4;
            end
        end
        @(posedge clk);
        @(negedge clk);
    endtask

    initial begin
        m_pc = 32'd0;
        q.delete();

        // Reset state
        @(negedge clk);
        #1;
        chk("rst_imem_addr", imem_addr, 32'h0);
        chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
        chk("rst_out_instr", out_instr, 32'h0);
        chk("rst_out_pc", out_pc, 32'h0);
        chk("rst_out_pc_plus4", out_pc_plus4, 32'h4);
        chk("rst_imem_addr2", imem_addr2, 32'hFFFF_FFF8);

        // Streaming, with the wrapping instance running alongside
        rst = 1'b0; fetch_en = 1'b1; out_ready = 1'b1; fe2 = 1'b1; rdy2 = 1'b1;
        step();
        chk("first_out_pc", out_pc, 32'h0);
        chk("wrap_pc0", out_pc2, 32'hFFFF_FFF8);
        step();
        chk("wrap_pc1", out_pc2, 32'hFFFF_FFFC);
        chk("wrap_plus4", out_pc_plus4_2, 32'h0);
        step();
        chk("wrap_pc2", out_pc2, 32'h0);
        chk("wrap_instr2", out_instr2, memf(32'h0));
        repeat (5) step();

        // Backpressure from an empty FIFO at PC 0
        redirect_valid = 1'b1; redirect_pc = 32'h0; out_ready = 1'b0;
        step();
        redirect_valid = 1'b0;
        repeat (4) step();
        chk("bp_imem_hold", imem_addr, 32'h8);
        chk("bp_out_pc_hold", out_pc, 32'h0);
        out_ready = 1'b1;
        step();
        chk("bp_rel_pc4", out_pc, 32'h4);
        step();
        chk("bp_rel_pc8", out_pc, 32'h8);
        step();
        chk("bp_rel_pcC", out_pc, 32'hC);

        // Redirect while full
        out_ready = 1'b0;
        repeat (2) step();
        redirect_valid = 1'b1; redirect_pc = 32'h100;
        step();
        redirect_valid = 1'b0;
        chk("redir_valid_next", {31'd0, out_valid}, 32'd0);
        step();
        chk("redir_target_pc", out_pc, 32'h100);
        chk("redir_target_valid", {31'd0, out_valid}, 32'd1);

        // Redirect alongside out_ready, misaligned target
        out_ready = 1'b1; redirect_valid = 1'b1; redirect_pc = 32'h0000_0103;
        step();
        redirect_valid = 1'b0;
        chk("misalign_imem", imem_addr, 32'h100);
        step();
        chk("misalign_out_pc", out_pc, 32'h100);

        // Randomized traffic
        for (int i = 0; i < 300; i++) begin
            fetch_en       = ($urandom_range(0, 3) != 0);
            out_ready      = ($urandom_range(0, 2) != 0);
            redirect_valid = ($urandom_range(0, 7) == 0);
            redirect_pc    = $urandom;
            step();
        end

        // fetch_en low drains two queued entries and freezes the PC
        fetch_en = 1'b1; out_ready = 1'b0; redirect_valid = 1'b1; redirect_pc = 32'h200;
        step();
        redirect_valid = 1'b0;
        repeat (3) step();
        fetch_en = 1'b0; out_ready = 1'b1;
        repeat (2) step();
        chk("drain_valid", {31'd0, out_valid}, 32'd0);
        chk("drain_pc_hold", imem_addr, 32'h208);
        step();

        // Asynchronous reset between edges
        fetch_en = 1'b1; out_ready = 1'b1;
        repeat (3) step();
        #2;
        rst = 1'b1;
        #1;
        chk("arst_out_valid", {31'd0, out_valid}, 32'd0);
        chk("arst_imem_addr", imem_addr, 32'h0);
        chk("arst_out_pc", out_pc, 32'h0);
        chk("arst_out_instr", out_instr, 32'h0);
        chk("arst_out_pc_plus4", out_pc_plus4, 32'h4);
        q.delete();
        m_pc = 32'd0;
        @(negedge clk);
        rst = 1'b0;
        repeat (4) step();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
